// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), sync polarity constants and helpers
// used by vga_timing_gen and its per-axis counters.
package vga_pkg;

    localparam int H_DISPLAY_640     = 640;
    localparam int H_FRONT_PORCH_640 = 16;
    localparam int H_SYNC_PULSE_640  = 96;
    localparam int H_BACK_PORCH_640  = 48;
    localparam int V_DISPLAY_480     = 480;
    localparam int V_FRONT_PORCH_480 = 10;
    localparam int V_SYNC_PULSE_480  = 2;
    localparam int V_BACK_PORCH_480  = 33;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;
    localparam int MAX_PIPE_DELAY   = 4;

    typedef struct packed {
        logic display_area;
        logic h_sync;
        logic v_sync;
    } vga_sig_t;

    function automatic int seg_total(input int display, input int front,
                                     input int sync, input int back);
        return display + front + sync + back;
    endfunction

    // RGB444 colour bars, left to right; anything past the eighth bar is black.
    function automatic logic [11:0] bar_colour(input int idx);
        case (idx)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video output bundle from vga_timing_gen to the renderer / colour mux.
// rgb exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
    parameter int COORD_BITS     = 10,
    parameter int FRAME_CNT_BITS = 8
);
    logic [COORD_BITS-1:0]     X;
    logic [COORD_BITS-1:0]     Y;
    logic                      display_area;
    logic                      h_sync;
    logic                      v_sync;
    logic                      line_tik;
    logic                      frame_tik;
    logic [FRAME_CNT_BITS-1:0] frame_count;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0]               rgb;
`endif

    modport master (
        output X, Y, display_area, h_sync, v_sync, line_tik, frame_tik, frame_count
`ifdef VGA_TEST_PATTERN_EN
        , output rgb
`endif
    );

    modport slave (
        input X, Y, display_area, h_sync, v_sync, line_tik, frame_tik, frame_count
`ifdef VGA_TEST_PATTERN_EN
        , input rgb
`endif
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus active/sync segment decode.
// carry pulses on the advancing cycle that wraps the counter.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int DISPLAY     = H_DISPLAY_640,
    parameter int FRONT_PORCH = H_FRONT_PORCH_640,
    parameter int SYNC_PULSE  = H_SYNC_PULSE_640,
    parameter int BACK_PORCH  = H_BACK_PORCH_640,
    parameter int CNT_BITS    = 10
) (
    input  logic                clock_25,
    input  logic                reset,
    input  logic                advance,
    output logic [CNT_BITS-1:0] count,
    output logic                active,
    output logic                in_sync,
    output logic                end_active,
    output logic                carry
);
    localparam int TOTAL      = seg_total(DISPLAY, FRONT_PORCH, SYNC_PULSE, BACK_PORCH);
    localparam int SYNC_START = DISPLAY + FRONT_PORCH;
    localparam int SYNC_END   = SYNC_START + SYNC_PULSE;

    logic [31:0] cnt_w;
    logic        at_wrap;

    // Decode in 32 bits so SYNC_END == TOTAL cannot overflow CNT_BITS.
    assign cnt_w      = 32'(count);
    assign at_wrap    = (cnt_w == 32'(TOTAL - 1));
    assign active     = (cnt_w < 32'(DISPLAY));
    assign in_sync    = (cnt_w >= 32'(SYNC_START)) && (cnt_w < 32'(SYNC_END));
    assign end_active = advance && (cnt_w == 32'(DISPLAY - 1));
    assign carry      = advance && at_wrap;

    always_ff @(posedge clock_25) begin
        if (reset)
            count <= '0;
        else if (advance)
            count <= at_wrap ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel enable, ticks, frame counter and
// pixel-aligned output delay. Define VGA_TEST_PATTERN_EN to add a colour-bar rgb output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY      = H_DISPLAY_640,
    parameter int H_FRONT_PORCH  = H_FRONT_PORCH_640,
    parameter int H_SYNC_PULSE   = H_SYNC_PULSE_640,
    parameter int H_BACK_PORCH   = H_BACK_PORCH_640,
    parameter int V_DISPLAY      = V_DISPLAY_480,
    parameter int V_FRONT_PORCH  = V_FRONT_PORCH_480,
    parameter int V_SYNC_PULSE   = V_SYNC_PULSE_480,
    parameter int V_BACK_PORCH   = V_BACK_PORCH_480,
    parameter bit H_SYNC_POL     = SYNC_ACTIVE_LOW,
    parameter bit V_SYNC_POL     = SYNC_ACTIVE_LOW,
    parameter int COORD_BITS     = 10,
    parameter int PIPE_DELAY     = 0,
    parameter int FRAME_CNT_BITS = 8
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic             pixel_en,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = seg_total(H_DISPLAY, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
    localparam int V_TOTAL = seg_total(V_DISPLAY, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);
    localparam vga_sig_t SIG_IDLE = '{display_area: 1'b0, h_sync: ~H_SYNC_POL, v_sync: ~V_SYNC_POL};

    if ($clog2(H_TOTAL) > COORD_BITS || $clog2(V_TOTAL) > COORD_BITS) begin : g_bad_coord
        $fatal(1, "vga_timing_gen: COORD_BITS=%0d cannot hold H_TOTAL-1/V_TOTAL-1", COORD_BITS);
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_delay
        $fatal(1, "vga_timing_gen: PIPE_DELAY=%0d outside 0..%0d", PIPE_DELAY, MAX_PIPE_DELAY);
    end

    logic [COORD_BITS-1:0]     h_cnt, v_cnt;
    logic                      h_active, h_in_sync, h_end_active, h_carry;
    logic                      v_active, v_in_sync, v_end_active, v_carry_unused;
    logic                      line_tik, frame_tik;
    logic [FRAME_CNT_BITS-1:0] frame_count;
    vga_sig_t                  sig_now;
    vga_sig_t                  sig_pipe [PIPE_DELAY:0];

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT_PORCH(H_FRONT_PORCH), .SYNC_PULSE(H_SYNC_PULSE),
        .BACK_PORCH(H_BACK_PORCH), .CNT_BITS(COORD_BITS)
    ) u_h_axis (
        .clock_25(clock_25), .reset(reset), .advance(pixel_en), .count(h_cnt),
        .active(h_active), .in_sync(h_in_sync), .end_active(h_end_active), .carry(h_carry)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT_PORCH(V_FRONT_PORCH), .SYNC_PULSE(V_SYNC_PULSE),
        .BACK_PORCH(V_BACK_PORCH), .CNT_BITS(COORD_BITS)
    ) u_v_axis (
        .clock_25(clock_25), .reset(reset), .advance(h_carry), .count(v_cnt),
        .active(v_active), .in_sync(v_in_sync), .end_active(v_end_active), .carry(v_carry_unused)
    );

    assign sig_now = '{display_area: h_active & v_active,
                       h_sync:       h_in_sync ? H_SYNC_POL : ~H_SYNC_POL,
                       v_sync:       v_in_sync ? V_SYNC_POL : ~V_SYNC_POL};

    // Stage 0 is the decode register; further stages shift per pixel, not per clock.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            for (int i = 0; i <= PIPE_DELAY; i++) sig_pipe[i] <= SIG_IDLE;
        end else if (pixel_en) begin
            sig_pipe[0] <= sig_now;
            for (int i = 1; i <= PIPE_DELAY; i++) sig_pipe[i] <= sig_pipe[i-1];
        end
    end

    // v_end_active fires on the last pixel of the last active line: entry to front porch.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            line_tik    <= 1'b0;
            frame_tik   <= 1'b0;
            frame_count <= '0;
        end else begin
            line_tik  <= h_end_active & v_active;
            frame_tik <= v_end_active;
            if (v_end_active) frame_count <= frame_count + 1'b1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_DISPLAY / 8 > 0) ? H_DISPLAY / 8 : 1;

    logic [11:0] rgb_now;
    logic [11:0] rgb_pipe [PIPE_DELAY:0];

    always_comb begin
        rgb_now = 12'h000;
        if (h_active && v_active) begin
            if (h_cnt == '0 || h_cnt == COORD_BITS'(H_DISPLAY - 1) ||
                v_cnt == '0 || v_cnt == COORD_BITS'(V_DISPLAY - 1))
                rgb_now = 12'hFFF;
            else
                rgb_now = bar_colour(int'(h_cnt) / BAR_W);
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            for (int i = 0; i <= PIPE_DELAY; i++) rgb_pipe[i] <= 12'h000;
        end else if (pixel_en) begin
            rgb_pipe[0] <= rgb_now;
            for (int i = 1; i <= PIPE_DELAY; i++) rgb_pipe[i] <= rgb_pipe[i-1];
        end
    end

    assign vga.rgb = rgb_pipe[PIPE_DELAY];
`endif

    assign vga.X            = h_cnt;
    assign vga.Y            = v_cnt;
    assign vga.display_area = sig_pipe[PIPE_DELAY].display_area;
    assign vga.h_sync       = sig_pipe[PIPE_DELAY].h_sync;
    assign vga.v_sync       = sig_pipe[PIPE_DELAY].v_sync;
    assign vga.line_tik     = line_tik;
    assign vga.frame_tik    = frame_tik;
    assign vga.frame_count  = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken mode; expected outputs come from
// the pixel index since reset, checked by an independent negedge monitor.
module tb_vga_timing_gen;

    localparam int HD = 16, HFP = 2, HSP = 3, HBP = 3;
    localparam int VD = 6,  VFP = 1, VSP = 2, VBP = 2;
    localparam int HT = HD + HFP + HSP + HBP;
    localparam int VT = VD + VFP + VSP + VBP;
    localparam int FRAME = HT * VT;
    localparam int CB = 5, PD = 2, FCB = 2;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;

    logic clock_25 = 1'b0;
    logic reset    = 1'b1;
    logic pixel_en = 1'b0;

    always #20 clock_25 = ~clock_25;

    vga_timing_gen_if #(.COORD_BITS(CB), .FRAME_CNT_BITS(FCB)) vga ();

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
        .V_DISPLAY(VD), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .COORD_BITS(CB), .PIPE_DELAY(PD),
        .FRAME_CNT_BITS(FCB)
    ) dut (
        .clock_25(clock_25), .reset(reset), .pixel_en(pixel_en), .vga(vga)
    );

    typedef struct packed {
        logic [CB-1:0]  x;
        logic [CB-1:0]  y;
        logic           da;
        logic           hs;
        logic           vs;
        logic           lt;
        logic           ft;
        logic [FCB-1:0] fc;
`ifdef VGA_TEST_PATTERN_EN
        logic [11:0]    rgb;
`endif
    } obs_t;

    obs_t sb[$];
    int   n = 0;           // enabled pixels since the last reset
    int   checks = 0;
    int   errors = 0;

    // Expected state after a clock edge, given n and the ticks produced by that edge.
    function automatic obs_t model(input int cnt, input bit lt, input bit ft);
        obs_t e;
        int   k, kx, ky;
        logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                  12'hF0F, 12'hF00, 12'h00F, 12'h000};
        e    = '0;
        e.x  = CB'(cnt % HT);
        e.y  = CB'((cnt / HT) % VT);
        e.lt = lt;
        e.ft = ft;
        e.fc = FCB'((cnt >= VD * HT) ? (cnt - VD * HT) / FRAME + 1 : 0);
        k    = cnt - 1 - PD;   // pixel whose decode is visible at the output now
        if (k < 0) begin
            e.da = 1'b0;
            e.hs = ~HPOL;
            e.vs = ~VPOL;
        end else begin
            kx   = k % HT;
            ky   = (k / HT) % VT;
            e.da = (kx < HD) && (ky < VD);
            e.hs = (kx >= HD + HFP && kx < HD + HFP + HSP) ? HPOL : ~HPOL;
            e.vs = (ky >= VD + VFP && ky < VD + VFP + VSP) ? VPOL : ~VPOL;
`ifdef VGA_TEST_PATTERN_EN
            if (e.da)
                e.rgb = (kx == 0 || kx == HD - 1 || ky == 0 || ky == VD - 1) ? 12'hFFF
                                                                             : bars[kx / (HD / 8)];
`endif
        end
        return e;
    endfunction

    task automatic step(input bit rst, input bit en);
        bit lt, ft;
        int px, py;
        reset    = rst;
        pixel_en = en;
        @(posedge clock_25);
        lt = 1'b0;
        ft = 1'b0;
        if (rst) begin
            n = 0;
        end else if (en) begin
            px = n % HT;
            py = (n / HT) % VT;
            lt = (px == HD - 1) && (py < VD);
            ft = (px == HT - 1) && (py == VD - 1);
            n  = n + 1;
        end
        sb.push_back(model(n, lt, ft));
        #1;
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clock_25);
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                a    = '0;
                a.x  = vga.X;
                a.y  = vga.Y;
                a.da = vga.display_area;
                a.hs = vga.h_sync;
                a.vs = vga.v_sync;
                a.lt = vga.line_tik;
                a.ft = vga.frame_tik;
                a.fc = vga.frame_count;
`ifdef VGA_TEST_PATTERN_EN
                a.rgb = vga.rgb;
`endif
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got x=%0d y=%0d da=%b hs=%b vs=%b lt=%b ft=%b fc=%0d raw=%h exp x=%0d y=%0d da=%b hs=%b vs=%b lt=%b ft=%b fc=%0d raw=%h",
                             $time, a.x, a.y, a.da, a.hs, a.vs, a.lt, a.ft, a.fc, a,
                             e.x, e.y, e.da, e.hs, e.vs, e.lt, e.ft, e.fc, e);
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        // reset must win over pixel_en
        repeat (3) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (FRAME + 150) step(1'b0, 1'b1);
        repeat (600) step(1'b0, ($urandom % 4) != 0);
        for (int i = 0; i < 300; i++) step(1'b0, (i % 2) == 0);

        // park inside both sync pulses, then reset there
        guard = 0;
        while (!((n % HT) >= HD + HFP && (n % HT) < HD + HFP + HSP &&
                 ((n / HT) % VT) >= VD + VFP && ((n / HT) % VT) < VD + VFP + VSP) &&
               guard < 2 * FRAME) begin
            step(1'b0, 1'b1);
            guard++;
        end
        step(1'b1, 1'b1);
        // long enough for frame_count to wrap 3 -> 0
        repeat (4 * FRAME + 20) step(1'b0, 1'b1);
        repeat (800) step(($urandom % 150) == 0, ($urandom % 3) != 0);
        step(1'b0, 1'b0);

        repeat (3) @(negedge clock_25);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator. It is the next generation of the fixed 640x480 tracker.
- Timings, sync polarities and coordinate width are set by parameters.
- A pixel-enable input allows running from a faster clock.
- All outputs are registered.
- Adds line/frame ticks, a frame counter and a programmable sync/display-enable delay that aligns with downstream pixel pipelines (sprite/snake renderer).
- Sits between the clock source and the renderer/colour mux.

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT_PORCH, 16, horizontal front porch (pixels)
H_SYNC_PULSE, 96, horizontal sync width (pixels)
H_BACK_PORCH, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines
V_FRONT_PORCH, 10, vertical front porch (lines)
V_SYNC_PULSE, 2, vertical sync width (lines)
V_BACK_PORCH, 33, vertical back porch (lines)
H_SYNC_POL, 0, active level of h_sync (0 = active-low)
V_SYNC_POL, 0, active level of v_sync
COORD_BITS, 10, width of X/Y; must hold H_TOTAL-1 and V_TOTAL-1
PIPE_DELAY, 0, extra register stages (0..4) on h_sync/v_sync/display_area
FRAME_CNT_BITS, 8, frame counter width

Ports:
clock_25  input  1  pixel clock
reset  input  1  synchronous, active-high reset
pixel_en  input  1  advance timing by one pixel when high; tie to 1 for a true 25.175 MHz clock
X  output  COORD_BITS  horizontal counter; 0..H_DISPLAY-1 during active video
Y  output  COORD_BITS  vertical counter; 0..V_DISPLAY-1 during active lines
display_area  output  1  high during active video (delayed by PIPE_DELAY)
h_sync  output  1  horizontal sync, polarity H_SYNC_POL (delayed by PIPE_DELAY)
v_sync  output  1  vertical sync, polarity V_SYNC_POL (delayed by PIPE_DELAY)
line_tik  output  1  one-cycle pulse at the end of each active line
frame_tik  output  1  one-cycle pulse at the start of vertical front porch
frame_count  output  FRAME_CNT_BITS  completed-frame counter, wraps

Behaviour:
- Derived constants: H_TOTAL = sum of the H_ parameters (800 default); V_TOTAL = sum of the V_ parameters (525 default).
- Line order, horizontal: active [0, H_DISPLAY), front porch, sync, back porch.
  - Sync asserted for h_cnt in [H_DISPLAY+H_FRONT_PORCH, H_DISPLAY+H_FRONT_PORCH+H_SYNC_PULSE).
  - Vertical uses the same ordering on v_cnt.
- Internal counters h_cnt and v_cnt change only on cycles with pixel_en=1.
  - h_cnt wraps H_TOTAL-1 -> 0; v_cnt increments on that wrap.
  - v_cnt wraps V_TOTAL-1 -> 0.
- X = h_cnt, Y = v_cnt. These are the registers themselves, so there is no extra latency.
- Decoded outputs are registered: the value present in cycle t+1 reflects the counters in cycle t, then passes through PIPE_DELAY further stages.
- The delay stages shift only when pixel_en=1, so alignment is in pixels, not clocks.
- line_tik: high for exactly one clock when pixel_en=1 and h_cnt==H_DISPLAY-1 and v_cnt<V_DISPLAY. Registered with 1-cycle latency; not delayed by PIPE_DELAY.
- frame_tik: high for one clock when pixel_en=1, h_cnt==H_TOTAL-1 and v_cnt==V_DISPLAY-1, i.e. entering front porch. Latency 1; not delayed.
- frame_count increments in the same cycle frame_tik is asserted; wraps at 2^FRAME_CNT_BITS.
- pixel_en=0: all outputs hold their values; ticks are 0.
- Reset (any cycle, including mid-line or mid-sync):
  - h_cnt, v_cnt, X, Y, frame_count = 0; line_tik = frame_tik = 0.
  - display_area = 0.
  - h_sync = ~H_SYNC_POL and v_sync = ~V_SYNC_POL (inactive), including every delay stage.
  - Timing restarts from pixel (0,0) on the first enabled cycle after reset deasserts.
  - Reset overrides pixel_en.
- Counter range is checked at elaboration. COORD_BITS too small, or PIPE_DELAY>4, is a fatal error.

Optional Feature:
VGA_TEST_PATTERN_EN:
- Defined: adds output rgb[11:0] with PIPE_DELAY alignment. During display_area it shows 8 vertical colour bars, each H_DISPLAY/8 wide (white, yellow, cyan, green, magenta, red, blue, black), with a 1-pixel white border at X=0, X=H_DISPLAY-1, Y=0 and Y=V_DISPLAY-1. rgb is 0 outside display_area and at reset.
- Not defined: no rgb port and no logic.

Decomposition:
- Shared package vga_pkg: default 640x480@60 timing constants, polarity constants, and a function computing the total from the four segment lengths.
- One natural sub-module, vga_axis_counter: a single counter with segment decode (active/sync/wrap outputs), instantiated twice (horizontal and vertical). Vertical advances on the horizontal wrap.

Test Plan:
- Defaults, pixel_en=1, 2 frames -> line period 800 clocks; h_sync low for 96 clocks starting at X=656; v_sync low for 2 lines at Y=490..491; display_area high for 640x480 clocks per frame.
- frame_tik -> exactly one pulse per 420000 clocks; frame_count 0 -> 1 -> 2; line_tik 480 pulses per frame, each at X=639.
- pixel_en toggling 1,0 (50 MHz mode) -> identical output sequence per enabled cycle; line period 1600 clocks; outputs stable while pixel_en=0; ticks exactly one clock wide.
- PIPE_DELAY=2 -> h_sync/display_area edges lag the PIPE_DELAY=0 waveform by exactly 2 pixels; X/Y and ticks unchanged.
- H_SYNC_POL=1, V_SYNC_POL=1 -> syncs are the inverse of the default run; reset value is 0.
- Reset asserted at X=700, Y=491 (during both syncs) -> next cycle X=Y=0, syncs inactive, frame_count=0; normal timing resumes afterwards. FRAME_CNT_BITS=2 wraps 3 -> 0.
